// File: rtl/global_param_pkg.sv
// Shared types and constants for the global parameter bank: FSM state encoding,
// byte width, and the bytes-per-register helper.
package global_param_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_READ   = 2'd3
    } state_t;

    function automatic int bytes_per_reg(input int reg_w);
        return reg_w / BYTE_W;
    endfunction

endpackage

// File: rtl/gpb_seq_counter.sv
// Flat byte index over the whole parameter bank (register 0 byte 0 first),
// shared by the load and readback sequences.
module gpb_seq_counter #(
    parameter int TOTAL = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    assign last = (idx == IDX_W'(TOTAL - 1));

    // Wrap at the last byte so the index can never point past the bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/global_param_bank.sv
// Byte-serial loader for a bank of global parameter registers with atomic commit.
// Optional readback path enabled by defining GPB_READBACK_EN.
module global_param_bank
    import global_param_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int REG_W    = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      WR_START,
    input  logic [7:0]                WDATA,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic                      RD_START,
    output logic [7:0]                RDATA,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [NUM_REGS*REG_W-1:0] PARAMS,
    output logic                      LOAD_DONE,
    output logic                      READ_DONE,
    output logic                      BUSY
);

    localparam int TOTAL_BYTES = NUM_REGS * bytes_per_reg(REG_W);
    localparam int IDX_W       = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
    localparam int P_W         = NUM_REGS * REG_W;

    state_t             state, state_next;
    logic               cnt_clear, cnt_adv, cnt_last, shadow_wr;
    logic [IDX_W-1:0]   idx;
    logic [P_W-1:0]     shadow;

    gpb_seq_counter #(
        .TOTAL(TOTAL_BYTES),
        .IDX_W(IDX_W)
    ) u_seq_counter (
        .clk    (ACLK),
        .rst    (ARESET),
        .clear  (cnt_clear),
        .advance(cnt_adv),
        .idx    (idx),
        .last   (cnt_last)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_adv    = 1'b0;
        shadow_wr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (WR_START) begin
                    state_next = ST_LOAD;
                    cnt_clear  = 1'b1;
`ifdef GPB_READBACK_EN
                end else if (RD_START) begin
                    state_next = ST_READ;
                    cnt_clear  = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                // A restart wins over a byte arriving in the same cycle.
                if (WR_START) begin
                    cnt_clear = 1'b1;
                end else if (WVALID) begin
                    shadow_wr = 1'b1;
                    if (cnt_last) state_next = ST_COMMIT;
                    else          cnt_adv    = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
            end
`ifdef GPB_READBACK_EN
            ST_READ: begin
                if (RREADY) begin
                    if (cnt_last) state_next = ST_IDLE;
                    else          cnt_adv    = 1'b1;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            shadow <= '0;
        end else if (state == ST_LOAD && WR_START) begin
            shadow <= '0;
        end else if (shadow_wr) begin
            shadow[int'(idx)*BYTE_W +: BYTE_W] <= WDATA;
        end
    end

    // Active values only move on the COMMIT cycle, so partial loads are invisible.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                 PARAMS <= '0;
        else if (state == ST_COMMIT) PARAMS <= shadow;
    end

    assign WREADY    = (state == ST_LOAD);
    assign LOAD_DONE = (state == ST_COMMIT);
    assign BUSY      = (state != ST_IDLE);

`ifdef GPB_READBACK_EN
    logic read_done_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) read_done_q <= 1'b0;
        else        read_done_q <= (state == ST_READ) && RREADY && cnt_last;
    end

    always_comb begin
        RDATA = '0;
        if (state == ST_READ) RDATA = PARAMS[int'(idx)*BYTE_W +: BYTE_W];
    end

    assign RVALID    = (state == ST_READ);
    assign READ_DONE = read_done_q;
`else
    logic unused_readback;
    assign unused_readback = &{1'b0, RD_START, RREADY};
    assign RDATA     = '0;
    assign RVALID    = 1'b0;
    assign READ_DONE = 1'b0;
`endif

endmodule

// File: doc/global_param_bank.md
GLOBAL_PARAM_BANK -- requirements
Module: global_param_bank

Interface
REQ-001 Parameter NUM_REGS, default 4: number of global parameter registers (1..16).
REQ-002 Parameter REG_W, default 8: register width in bits; SHALL be a multiple of 8 (8..32).
REQ-003 ACLK  in  1  sole clock, rising edge.
REQ-004 ARESET  in  1  reset; asynchronous, active-high.
REQ-005 WR_START  in  1  single-cycle request to begin a load sequence.
REQ-006 WDATA  in  8  load byte; WVALID  in  1  byte valid; WREADY  out  1  byte accepted when WVALID&&WREADY.
REQ-007 RD_START  in  1  single-cycle request to begin a readback sequence.
REQ-008 RDATA  out  8  readback byte; RVALID  out  1; RREADY  in  1; beat completes when RVALID&&RREADY.
REQ-009 PARAMS  out  NUM_REGS*REG_W  active register values, register k at bits [k*REG_W +: REG_W].
REQ-010 LOAD_DONE  out  1  one-cycle pulse on commit; READ_DONE  out  1  one-cycle pulse at readback end.
REQ-011 BUSY  out  1  high in any state other than IDLE.

Function
REQ-012 States: IDLE, LOAD, COMMIT, READ.
REQ-013 IDLE: WR_START -> LOAD; RD_START -> READ; both same cycle -> LOAD (write wins).
REQ-014 LOAD: WREADY=1; bytes fill a shadow copy in order register 0 first, least-significant byte first; total NUM_REGS*REG_W/8 bytes.
REQ-015 Accepting the final byte -> COMMIT next cycle; COMMIT copies shadow to PARAMS, LOAD_DONE=1 for that one cycle, then IDLE.
REQ-016 PARAMS SHALL change only in COMMIT or reset; partial loads never alter PARAMS.
REQ-017 WR_START in LOAD restarts at byte 0 and discards shadow contents; a byte accepted the same cycle is discarded.
REQ-018 WVALID stalls hold the byte index; no timeout.
REQ-019 READ: RVALID=1, RDATA = current byte of PARAMS, same ordering as REQ-014; index advances only on a completed beat.
REQ-020 Final beat completion -> IDLE with READ_DONE=1 on the next cycle; RVALID low in that cycle.
REQ-021 WR_START and RD_START are ignored in READ and COMMIT; RD_START is ignored in LOAD.
REQ-022 Byte and register indices wrap to 0 on entry to LOAD or READ; no index beyond the last byte is ever used.

Reset
REQ-023 ARESET SHALL immediately force IDLE and clear PARAMS, shadow, indices, and all outputs to 0.
REQ-024 Reset mid-LOAD or mid-READ SHALL abandon the sequence with no LOAD_DONE or READ_DONE.

Configuration
REQ-025 Macro GPB_READBACK_EN defined: READ state and readback path present per REQ-019..REQ-020.
REQ-026 Macro GPB_READBACK_EN undefined: no READ state, RD_START ignored, RVALID/RDATA/READ_DONE tied 0.

Structure
REQ-027 Package global_param_pkg SHALL hold the state enum, BYTE_W=8, and a bytes-per-register constant function.
REQ-028 One sub-module, gpb_seq_counter: register/byte index counter with clear, advance, and last-byte flag, shared by LOAD and READ.

Verification (NUM_REGS=4, REG_W=8 unless noted)
REQ-029 WR_START, bytes 5,6,7,8 streamed back-to-back -> WREADY high 4 cycles, COMMIT next, PARAMS=0x08070605, LOAD_DONE one cycle.
REQ-030 Load of 1,2 then WR_START then 9,10,11,12 -> PARAMS=0x0C0B0A09, single LOAD_DONE.
REQ-031 After REQ-029, RD_START with RREADY low 3 cycles then high -> RDATA 5,6,7,8 in order, RDATA held during stall, READ_DONE after beat 4.
REQ-032 ARESET asserted after 2 bytes of a load -> PARAMS=0, BUSY=0 immediately, no LOAD_DONE; a fresh load then succeeds.
REQ-033 NUM_REGS=2, REG_W=16, bytes 0x34,0x12,0x78,0x56 -> PARAMS=0x56781234.
REQ-034 WR_START and RD_START same cycle in IDLE -> LOAD entered, RVALID stays 0; without GPB_READBACK_EN, RD_START alone -> BUSY stays 0.
